// File: rtl/data_bus_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
package data_bus_pkg;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        RESP
    } state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way winner select: round-robin or fixed M0 priority.
// The last-grant pointer moves only when a grant is actually taken.
module rr_arbiter_2
    import data_bus_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    input  logic       advance,
    output logic       winner,
    output logic       any
);
    logic r_last;

    always_comb begin
        any    = |req;
        winner = M0;
        if (req == 2'b10) begin
            winner = M1;
        end else if (req == 2'b11 && !fixed_prio) begin
            winner = ~r_last;
        end
    end

    // Reset to "M1 last" so M0 takes the first tie
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_last <= M1;
        end else if (advance && any) begin
            r_last <= winner;
        end
    end
endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one synchronous data RAM between the CPU data port (M0) and a
// secondary master (M1). Optional ARB_ACCESS_COUNT_EN adds grant counters.
module data_bus_arbiter
    import data_bus_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int FIXED_PRIO = 0
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef ARB_ACCESS_COUNT_EN
    input  logic          cnt_clr,
    output logic [7:0]    m0_count,
    output logic [7:0]    m1_count,
`endif
    input  logic [DW-1:0] mem_rdata
);
    state_t        r_state;
    logic          r_win;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_gnt;
    logic [1:0]    r_rvalid;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic          w_winner;
    logic          w_any;
    logic          w_adv;

    assign w_adv = (r_state == ARB);

    rr_arbiter_2 u_arb (
        .Clk       (Clk),
        .Rst       (Rst),
        .req       ({m1_req, m0_req}),
        .fixed_prio(FIXED_PRIO != 0),
        .advance   (w_adv),
        .winner    (w_winner),
        .any       (w_any)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ARB;
            r_win      <= M0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_gnt      <= 2'b00;
            r_rvalid   <= 2'b00;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                ARB: begin
                    if (w_any) begin
                        r_win    <= w_winner;
                        r_we     <= w_winner ? m1_we : m0_we;
                        r_addr   <= w_winner ? m1_addr : m0_addr;
                        r_wdata  <= w_winner ? m1_wdata : m0_wdata;
                        r_mem_en <= 1'b1;
                        r_mem_we <= w_winner ? m1_we : m0_we;
                        r_gnt    <= w_winner ? 2'b10 : 2'b01;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= r_we ? ARB : RESP;
                end
                RESP: begin
                    // RAM data for the ISSUE-cycle read is valid now
                    if (r_win == M1) begin
                        r_m1_rdata <= mem_rdata;
                        r_rvalid   <= 2'b10;
                    end else begin
                        r_m0_rdata <= mem_rdata;
                        r_rvalid   <= 2'b01;
                    end
                    r_state <= ARB;
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

`ifdef ARB_ACCESS_COUNT_EN
    logic [7:0] r_m0_count;
    logic [7:0] r_m1_count;

    // A clear coinciding with a grant wins
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_m0_count <= '0;
            r_m1_count <= '0;
        end else if (cnt_clr) begin
            r_m0_count <= '0;
            r_m1_count <= '0;
        end else begin
            if (r_gnt[0] && r_m0_count != 8'hFF) begin
                r_m0_count <= r_m0_count + 8'd1;
            end
            if (r_gnt[1] && r_m1_count != 8'hFF) begin
                r_m1_count <= r_m1_count + 8'd1;
            end
        end
    end

    assign m0_count = r_m0_count;
    assign m1_count = r_m1_count;
`endif
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter with a RAM model and a
// transaction-level reference of arbitration order and timing.
module tb_data_bus_arbiter;
    logic       Clk = 1'b0;
    logic       Rst;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr  [2];
    logic [7:0] wdata [2];
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [7:0] rdata [2];
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] ram [256];

    logic [1:0] f_req;
    logic [1:0] f_gnt;
    logic [1:0] f_rvalid;
    logic [7:0] f_rdata [2];
    logic       f_mem_en;
    logic       f_mem_we;
    logic [7:0] f_mem_addr;
    logic [7:0] f_mem_wdata;

`ifdef ARB_ACCESS_COUNT_EN
    logic       cnt_clr;
    logic [7:0] m0_count;
    logic [7:0] m1_count;
    logic [7:0] f_cnt0;
    logic [7:0] f_cnt1;
`endif

    int         vec = 0;
    int         bad = 0;
    int         last_g;
    logic [7:0] exp_mem [256];
    logic [7:0] exp_rd  [2];

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    data_bus_arbiter #(.FIXED_PRIO(0)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .m0_req   (req[0]),
        .m0_we    (we[0]),
        .m0_addr  (addr[0]),
        .m0_wdata (wdata[0]),
        .m0_gnt   (gnt[0]),
        .m0_rvalid(rvalid[0]),
        .m0_rdata (rdata[0]),
        .m1_req   (req[1]),
        .m1_we    (we[1]),
        .m1_addr  (addr[1]),
        .m1_wdata (wdata[1]),
        .m1_gnt   (gnt[1]),
        .m1_rvalid(rvalid[1]),
        .m1_rdata (rdata[1]),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
`ifdef ARB_ACCESS_COUNT_EN
        .cnt_clr  (cnt_clr),
        .m0_count (m0_count),
        .m1_count (m1_count),
`endif
        .mem_rdata(mem_rdata)
    );

    data_bus_arbiter #(.FIXED_PRIO(1)) dut_f (
        .Clk      (Clk),
        .Rst      (Rst),
        .m0_req   (f_req[0]),
        .m0_we    (1'b1),
        .m0_addr  (8'h50),
        .m0_wdata (8'h11),
        .m0_gnt   (f_gnt[0]),
        .m0_rvalid(f_rvalid[0]),
        .m0_rdata (f_rdata[0]),
        .m1_req   (f_req[1]),
        .m1_we    (1'b1),
        .m1_addr  (8'h51),
        .m1_wdata (8'h22),
        .m1_gnt   (f_gnt[1]),
        .m1_rvalid(f_rvalid[1]),
        .m1_rdata (f_rdata[1]),
        .mem_en   (f_mem_en),
        .mem_we   (f_mem_we),
        .mem_addr (f_mem_addr),
        .mem_wdata(f_mem_wdata),
`ifdef ARB_ACCESS_COUNT_EN
        .cnt_clr  (1'b0),
        .m0_count (f_cnt0),
        .m1_count (f_cnt1),
`endif
        .mem_rdata(8'h00)
    );

    task automatic do_reset;
        @(negedge Clk);
        Rst   = 1'b1;
        req   = 2'b00;
        f_req = 2'b00;
        @(negedge Clk);
        Rst       = 1'b0;
        last_g    = 1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
    endtask

    task automatic test_reset;
        Rst   = 1'b1;
        req   = 2'b00;
        f_req = 2'b00;
        we    = 2'b00;
        for (int m = 0; m < 2; m++) begin
            addr[m]  = 8'h00;
            wdata[m] = 8'h00;
        end
        #1;
        vec++;
        if ({gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata,
             rdata[0], rdata[1], f_gnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {gnt, rvalid, mem_en, mem_we, mem_addr,
                      mem_wdata, rdata[0], rdata[1], f_gnt});
        end
        @(negedge Clk);
        Rst       = 1'b0;
        last_g    = 1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge Clk);
        vec++;
        if ({gnt, mem_en} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: got %b want 000", {gnt, mem_en});
        end
    endtask

    task automatic test_m0_write;
        req[0] = 1'b1; we[0] = 1'b1;
        addr[0] = 8'h10; wdata[0] = 8'h0F;
        @(negedge Clk);
        vec++;
        if ({gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
            {2'b01, 1'b1, 1'b1, 8'h10, 8'h0F}) begin
            bad++;
            $display("FAIL m0_write_issue: got %h want %h",
                     {gnt, mem_en, mem_we, mem_addr, mem_wdata},
                     {2'b01, 1'b1, 1'b1, 8'h10, 8'h0F});
        end
        req[0] = 1'b0;
        exp_mem[8'h10] = 8'h0F;
        last_g = 0;
        @(negedge Clk);
        vec++;
        if ({gnt, mem_en, mem_we} !== 4'b0000) begin
            bad++;
            $display("FAIL m0_write_after: got %b want 0000",
                     {gnt, mem_en, mem_we});
        end
    endtask

    task automatic test_m1_read;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h10;
        @(negedge Clk);
        vec++;
        if ({gnt, mem_en, mem_we, mem_addr} !==
            {2'b10, 1'b1, 1'b0, 8'h10}) begin
            bad++;
            $display("FAIL m1_read_issue: got %h want %h",
                     {gnt, mem_en, mem_we, mem_addr},
                     {2'b10, 1'b1, 1'b0, 8'h10});
        end
        req[1] = 1'b0;
        last_g = 1;
        @(negedge Clk);
        vec++;
        if ({gnt, rvalid, mem_en} !== 5'b00000) begin
            bad++;
            $display("FAIL m1_read_wait: got %b want 00000",
                     {gnt, rvalid, mem_en});
        end
        @(negedge Clk);
        exp_rd[1] = exp_mem[8'h10];
        vec++;
        if ({rvalid, rdata[1], rdata[0]} !==
            {2'b10, exp_rd[1], exp_rd[0]}) begin
            bad++;
            $display("FAIL m1_read_data: got %h want %h",
                     {rvalid, rdata[1], rdata[0]},
                     {2'b10, exp_rd[1], exp_rd[0]});
        end
        @(negedge Clk);
        vec++;
        if (rvalid !== 2'b00) begin
            bad++;
            $display("FAIL m1_rvalid_pulse: got %b want 00", rvalid);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            req[0]   = 1'b1;
            we[0]    = 1'b1;
            addr[0]  = 8'h20 + 8'(i);
            wdata[0] = 8'($urandom);
            @(negedge Clk);
            vec++;
            if ({gnt, mem_en, mem_addr, mem_wdata} !==
                {2'b01, 1'b1, addr[0], wdata[0]}) begin
                bad++;
                $display("FAIL b2b_write[%0d]: got %h want %h", i,
                         {gnt, mem_en, mem_addr, mem_wdata},
                         {2'b01, 1'b1, addr[0], wdata[0]});
            end
            req[0] = 1'b0;
            exp_mem[addr[0]] = wdata[0];
            last_g = 0;
            @(negedge Clk);
        end
    endtask

    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            logic [1:0] en;
            logic [1:0] t_we;
            logic [7:0] t_a [2];
            logic [7:0] t_d [2];
            logic [7:0] vd  [2];
            int         gc  [2];
            int         vc  [2];
            int         ord [2];
            int         n;
            int         c;
            int         w;
            en   = 2'($urandom_range(0, 3));
            t_we = 2'($urandom_range(0, 3));
            for (int m = 0; m < 2; m++) begin
                t_a[m] = 8'h20 + 8'($urandom_range(0, 7));
                t_d[m] = 8'($urandom);
                vd[m]  = 8'h00;
                gc[m]  = -1;
                vc[m]  = -1;
                ord[m] = 0;
            end
            n = 0;
            if (en == 2'b11) begin
                ord[0] = (last_g == 0) ? 1 : 0;
                ord[1] = 1 - ord[0];
                n = 2;
            end else if (en != 2'b00) begin
                ord[0] = en[1] ? 1 : 0;
                n = 1;
            end
            // One grant per ARB visit; writes take 2 cycles, reads 3
            c = 1;
            for (int k = 0; k < n; k++) begin
                w = ord[k];
                gc[w] = c;
                if (t_we[w]) begin
                    exp_mem[t_a[w]] = t_d[w];
                    c += 2;
                end else begin
                    vd[w] = exp_mem[t_a[w]];
                    vc[w] = c + 2;
                    c += 3;
                end
                last_g = w;
            end
            req = en;
            we  = t_we;
            for (int m = 0; m < 2; m++) begin
                addr[m]  = t_a[m];
                wdata[m] = t_d[m];
            end
            for (int cyc = 1; cyc <= 8; cyc++) begin
                @(negedge Clk);
                for (int m = 0; m < 2; m++) begin
                    vec++;
                    if (gnt[m] !== (gc[m] == cyc)) begin
                        bad++;
                        $display("FAIL rnd%0d_gnt%0d c%0d: got %b want %b",
                                 r, m, cyc, gnt[m], gc[m] == cyc);
                    end
                    vec++;
                    if (rvalid[m] !== (vc[m] == cyc)) begin
                        bad++;
                        $display("FAIL rnd%0d_rvalid%0d c%0d: got %b want %b",
                                 r, m, cyc, rvalid[m], vc[m] == cyc);
                    end
                    if (vc[m] == cyc) exp_rd[m] = vd[m];
                    vec++;
                    if (rdata[m] !== exp_rd[m]) begin
                        bad++;
                        $display("FAIL rnd%0d_rdata%0d c%0d: got %h want %h",
                                 r, m, cyc, rdata[m], exp_rd[m]);
                    end
                end
                w = (gc[0] == cyc) ? 0 : ((gc[1] == cyc) ? 1 : -1);
                vec++;
                if (mem_en !== (w >= 0)) begin
                    bad++;
                    $display("FAIL rnd%0d_mem_en c%0d: got %b want %b",
                             r, cyc, mem_en, w >= 0);
                end
                if (w >= 0) begin
                    vec++;
                    if ({mem_we, mem_addr, mem_wdata} !==
                        {t_we[w], t_a[w], t_d[w]}) begin
                        bad++;
                        $display("FAIL rnd%0d_mem_bus c%0d: got %h want %h",
                                 r, cyc, {mem_we, mem_addr, mem_wdata},
                                 {t_we[w], t_a[w], t_d[w]});
                    end
                end else begin
                    vec++;
                    if (mem_we !== 1'b0) begin
                        bad++;
                        $display("FAIL rnd%0d_mem_we_idle c%0d: got %b want 0",
                                 r, cyc, mem_we);
                    end
                end
                for (int m = 0; m < 2; m++)
                    if (gnt[m] === 1'b1) req[m] = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin;
        int order [6];
        int cnt   [2];
        int rearm [2];
        int n;
        do_reset();
        we = 2'b11;
        addr[0] = 8'h30; wdata[0] = 8'hA0;
        addr[1] = 8'h31; wdata[1] = 8'hB1;
        cnt[0] = 0; cnt[1] = 0;
        rearm[0] = -1; rearm[1] = -1;
        n = 0;
        req = 2'b11;
        for (int cyc = 1; cyc <= 20 && n < 6; cyc++) begin
            @(negedge Clk);
            vec++;
            if (gnt === 2'b11) begin
                bad++;
                $display("FAIL rr_dual_gnt c%0d: got 11 want one-hot", cyc);
            end
            for (int m = 0; m < 2; m++) begin
                if (rearm[m] == cyc) req[m] = 1'b1;
                if (gnt[m] === 1'b1 && n < 6) begin
                    order[n] = m;
                    n++;
                    cnt[m]++;
                    req[m] = 1'b0;
                    rearm[m] = (cnt[m] < 3) ? cyc + 1 : -1;
                end
            end
        end
        req = 2'b00;
        vec++;
        if (n != 6) begin
            bad++;
            $display("FAIL rr_timeout: got %0d grants want 6", n);
        end
        for (int i = 0; i < n; i++) begin
            vec++;
            if (order[i] != i % 2) begin
                bad++;
                $display("FAIL rr_order[%0d]: got M%0d want M%0d",
                         i, order[i], i % 2);
            end
        end
        last_g = 1;
        @(negedge Clk);
    endtask

    task automatic test_fixed_prio;
        int exp_o [4];
        int order [4];
        int cnt0;
        int n;
        exp_o[0] = 0; exp_o[1] = 0; exp_o[2] = 0; exp_o[3] = 1;
        cnt0 = 0;
        n = 0;
        f_req = 2'b11;
        for (int cyc = 1; cyc <= 20 && n < 4; cyc++) begin
            @(negedge Clk);
            if (f_gnt === 2'b01 && cnt0 < 3 && cnt0 > 0) begin
                f_req[0] = 1'b0;
            end
            if (cyc > 1 && f_req[0] == 1'b0 && cnt0 < 3 &&
                f_gnt[0] !== 1'b1) begin
                f_req[0] = 1'b1;
            end
            if (f_gnt[0] === 1'b1) begin
                order[n] = 0;
                n++;
                cnt0++;
                f_req[0] = 1'b0;
            end else if (f_gnt[1] === 1'b1) begin
                order[n] = 1;
                n++;
                f_req[1] = 1'b0;
            end
        end
        f_req = 2'b00;
        vec++;
        if (n != 4) begin
            bad++;
            $display("FAIL fixed_timeout: got %0d grants want 4", n);
        end
        for (int i = 0; i < n; i++) begin
            vec++;
            if (order[i] != exp_o[i]) begin
                bad++;
                $display("FAIL fixed_order[%0d]: got M%0d want M%0d",
                         i, order[i], exp_o[i]);
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h21;
        @(negedge Clk);
        req[0] = 1'b0;
        @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        vec++;
        if ({gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata,
             rdata[0], rdata[1]} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async: got %h want 0",
                     {gnt, rvalid, mem_en, mem_we, mem_addr,
                      mem_wdata, rdata[0], rdata[1]});
        end
        @(negedge Clk);
        Rst       = 1'b0;
        last_g    = 1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            vec++;
            if ({gnt, rvalid, mem_en} !== 5'b00000) begin
                bad++;
                $display("FAIL rst_mid_quiet c%0d: got %b want 00000",
                         i, {gnt, rvalid, mem_en});
            end
        end
        we = 2'b11;
        addr[0] = 8'h32; addr[1] = 8'h33;
        req = 2'b11;
        @(negedge Clk);
        vec++;
        if (gnt !== 2'b01) begin
            bad++;
            $display("FAIL rst_mid_tie: got %b want 01", gnt);
        end
        req[0] = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        vec++;
        if (gnt !== 2'b10) begin
            bad++;
            $display("FAIL rst_mid_second: got %b want 10", gnt);
        end
        req[1] = 1'b0;
        last_g = 1;
        @(negedge Clk);
    endtask

`ifdef ARB_ACCESS_COUNT_EN
    task automatic test_count;
        int k;
        cnt_clr = 1'b0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            req[1] = 1'b1; we[1] = 1'b1;
            addr[1] = 8'h40; wdata[1] = 8'(i);
            for (k = 0; k < 4; k++) begin
                @(negedge Clk);
                if (gnt[1] === 1'b1) break;
            end
            req[1] = 1'b0;
            vec++;
            if (k == 4) begin
                bad++;
                $display("FAIL cnt_gnt_timeout[%0d]: got none want m1_gnt", i);
            end
            @(negedge Clk);
            if (i == 9) begin
                vec++;
                if (m1_count !== 8'd10) begin
                    bad++;
                    $display("FAIL cnt_ten: got %0d want 10", m1_count);
                end
            end
        end
        vec++;
        if ({m1_count, m0_count} !== {8'd255, 8'd0}) begin
            bad++;
            $display("FAIL cnt_sat: got %0d/%0d want 255/0",
                     m1_count, m0_count);
        end
        cnt_clr = 1'b1;
        @(negedge Clk);
        cnt_clr = 1'b0;
        vec++;
        if ({m1_count, m0_count} !== 16'h0000) begin
            bad++;
            $display("FAIL cnt_clr: got %0d/%0d want 0/0",
                     m1_count, m0_count);
        end
        req[1] = 1'b1;
        @(negedge Clk);
        req[1] = 1'b0;
        cnt_clr = 1'b1;
        @(negedge Clk);
        cnt_clr = 1'b0;
        vec++;
        if (m1_count !== 8'd0) begin
            bad++;
            $display("FAIL cnt_clr_wins: got %0d want 0", m1_count);
        end
        @(negedge Clk);
    endtask
`endif

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read();
        test_back_to_back();
        test_random(60);
        test_round_robin();
        test_fixed_prio();
        test_reset_mid();
        test_random(40);
`ifdef ARB_ACCESS_COUNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
